// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the 1-to-2 stream demux.
// Ports: none (package).
package demux_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    SEL_OUT0 = 1'b0,
    SEL_OUT1 = 1'b1
  } sel_t;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo2_slot.sv
// fifo2_slot: 2-entry FIFO, head and tail held in registers.
// Ports: clk, rst (sync, active-high), push/din in, pop in,
//   head out (registered), count (0..2), full, empty.
module fifo2_slot
  import demux_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output occ_t         count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] head_q;
  logic [W-1:0] head_d;
  logic [W-1:0] tail_q;
  logic [W-1:0] tail_d;
  occ_t         count_q;
  occ_t         count_d;
  logic         do_push;
  logic         do_pop;

  assign full    = (count_q == OCC_FULL);
  assign empty   = (count_q == OCC_EMPTY);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        if (empty) begin
          head_d = din;
        end else begin
          tail_d = din;
        end
        count_d = count_q + occ_t'(1);
      end
      2'b01: begin
        if (full) begin
          head_d = tail_q;
        end
        count_d = count_q - occ_t'(1);
      end
      // Only reachable at count 1: old head leaves,
      // the new word replaces it.
      2'b11: begin
        head_d = din;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= OCC_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/demux1to2_stream.sv
// demux1to2_stream: routes each input word by Sel into one of two
// independent 2-entry output buffers with their own handshakes.
// Ports: Clk, Rst (sync, active-high); Din/Sel/DinValid/DinReady in;
//   Dout0/Dout0Valid/Dout0Ready and Dout1/... out;
//   Cnt0/Cnt1 delivered-word counters only with DEMUX_STATS_EN.
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = demux_pkg::DATA_W,
  parameter int DEPTH  = demux_pkg::DEPTH
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Din,
  input  logic              Sel,
  input  logic              DinValid,
  output logic              DinReady,
  output logic [DATA_W-1:0] Dout0,
  output logic              Dout0Valid,
  input  logic              Dout0Ready,
  output logic [DATA_W-1:0] Dout1,
  output logic              Dout1Valid,
  input  logic              Dout1Ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  Cnt0,
  output logic [CNT_W-1:0]  Cnt1
`endif
);

  sel_t sel;
  occ_t occ0;
  occ_t occ1;
  occ_t sel_occ;
  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic accept;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  assign sel = sel_t'(Sel);

  // Ready looks only at the selected buffer's registered
  // count, so consumer ready never reaches DinReady.
  always_comb begin
    sel_occ = occ0;
    unique case (1'b1)
      (sel == SEL_OUT0): sel_occ = occ0;
      (sel == SEL_OUT1): sel_occ = occ1;
      default:           sel_occ = occ0;
    endcase
  end

  assign DinReady = (sel_occ != occ_t'(DEPTH)) & ~Rst;
  assign accept   = DinValid & DinReady;

  always_comb begin
    push0 = 1'b0;
    push1 = 1'b0;
    unique case (1'b1)
      (sel == SEL_OUT0): push0 = accept & ~full0;
      (sel == SEL_OUT1): push1 = accept & ~full1;
      default: begin
      end
    endcase
  end

  assign Dout0Valid = ~empty0;
  assign Dout1Valid = ~empty1;
  assign pop0       = Dout0Valid & Dout0Ready;
  assign pop1       = Dout1Valid & Dout1Ready;

  fifo2_slot #(
    .W(DATA_W)
  ) u_slot0 (
    .clk  (Clk),
    .rst  (Rst),
    .push (push0),
    .pop  (pop0),
    .din  (Din),
    .head (Dout0),
    .count(occ0),
    .full (full0),
    .empty(empty0)
  );

  fifo2_slot #(
    .W(DATA_W)
  ) u_slot1 (
    .clk  (Clk),
    .rst  (Rst),
    .push (push1),
    .pop  (pop1),
    .din  (Din),
    .head (Dout1),
    .count(occ1),
    .full (full1),
    .empty(empty1)
  );

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Saturating: a long-running count pins at max, never wraps.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (pop0) begin
        cnt0_q <= sat_inc(cnt0_q);
      end
      if (pop1) begin
        cnt1_q <= sat_inc(cnt1_q);
      end
    end
  end

  assign Cnt0 = cnt0_q;
  assign Cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// tb_demux1to2_stream: directed and random checks of the stream demux
// against a queue-based model (capacity 2 per output).
module tb_demux1to2_stream;
  import demux_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Din;
  logic        Sel;
  logic        DinValid;
  logic        DinReady;
  logic [31:0] Dout0;
  logic        Dout0Valid;
  logic        Dout0Ready;
  logic [31:0] Dout1;
  logic        Dout1Valid;
  logic        Dout1Ready;
`ifdef DEMUX_STATS_EN
  logic [15:0] Cnt0;
  logic [15:0] Cnt1;
  logic [15:0] m_cnt0;
  logic [15:0] m_cnt1;
`endif

  int pass_cnt = 0;
  int total = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  demux1to2_stream dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Din       (Din),
    .Sel       (Sel),
    .DinValid  (DinValid),
    .DinReady  (DinReady),
    .Dout0     (Dout0),
    .Dout0Valid(Dout0Valid),
    .Dout0Ready(Dout0Ready),
    .Dout1     (Dout1),
    .Dout1Valid(Dout1Valid),
    .Dout1Ready(Dout1Ready)
`ifdef DEMUX_STATS_EN
    ,
    .Cnt0      (Cnt0),
    .Cnt1      (Cnt1)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic bit exp_ready();
    if (Rst) return 1'b0;
    return Sel ? (q1.size() < 2) : (q0.size() < 2);
  endfunction

  // Model advances at the rising edge, then bench waits
  // for the falling edge to drive and compare.
  task automatic tick();
    bit pu;
    @(posedge Clk);
    pu = DinValid && exp_ready();
    if (Rst) begin
      q0.delete();
      q1.delete();
`ifdef DEMUX_STATS_EN
      m_cnt0 = '0;
      m_cnt1 = '0;
`endif
    end else begin
      if (q0.size() > 0 && Dout0Ready) begin
        void'(q0.pop_front());
`ifdef DEMUX_STATS_EN
        if (m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
`endif
      end
      if (q1.size() > 0 && Dout1Ready) begin
        void'(q1.pop_front());
`ifdef DEMUX_STATS_EN
        if (m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
`endif
      end
      if (pu) begin
        if (Sel) q1.push_back(Din);
        else q0.push_back(Din);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    DinValid = 1'b1;
    Sel = 1'b0;
    Din = 32'h1234_5678;
    tick();
    tick();
    total++;
    if (DinReady !== 1'b0)
      $display("FAIL rst_ready: got %b want 0", DinReady);
    else pass_cnt++;
    total++;
    if ({Dout0Valid, Dout1Valid} !== 2'b00)
      $display("FAIL rst_valid: got %b want 00", {Dout0Valid, Dout1Valid});
    else pass_cnt++;
    total++;
    if ({Dout0, Dout1} !== 64'h0)
      $display("FAIL rst_dout: got %h %h want 0 0", Dout0, Dout1);
    else pass_cnt++;
    Rst = 1'b0;
    DinValid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    Din = 32'hA5A5_A5A5;
    Sel = 1'b0;
    DinValid = 1'b1;
    Dout0Ready = 1'b1;
    #1;
    total++;
    if (DinReady !== 1'b1)
      $display("FAIL basic_ready: got %b want 1", DinReady);
    else pass_cnt++;
    total++;
    if (Dout0Valid !== 1'b0)
      $display("FAIL basic_nobypass: got %b want 0", Dout0Valid);
    else pass_cnt++;
    tick();
    DinValid = 1'b0;
    total++;
    if ({Dout0Valid, Dout0} !== {1'b1, 32'hA5A5_A5A5})
      $display("FAIL basic_out0: got %b %h want 1 a5a5a5a5", Dout0Valid, Dout0);
    else pass_cnt++;
    total++;
    if (Dout1Valid !== 1'b0)
      $display("FAIL basic_v1: got %b want 0", Dout1Valid);
    else pass_cnt++;
    tick();
    total++;
    if (Dout0Valid !== 1'b0)
      $display("FAIL basic_drain: got %b want 0", Dout0Valid);
    else pass_cnt++;
    Dout0Ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3];
    logic [31:0] got[$];
    w[0] = 32'h1111_1111;
    w[1] = 32'h2222_2222;
    w[2] = 32'h3333_3333;
    Dout1Ready = 1'b0;
    Sel = 1'b1;
    DinValid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      Din = w[i];
      #1;
      total++;
      if (DinReady !== 1'b1)
        $display("FAIL bp_accept%0d: got %b want 1", i, DinReady);
      else pass_cnt++;
      tick();
    end
    Din = w[2];
    #1;
    total++;
    if (DinReady !== 1'b0)
      $display("FAIL bp_full: got %b want 0", DinReady);
    else pass_cnt++;
    tick();
    Dout1Ready = 1'b1;
    #1;
    total++;
    if (DinReady !== 1'b0)
      $display("FAIL bp_full_pop: got %b want 0", DinReady);
    else pass_cnt++;
    got.push_back(Dout1);
    tick();
    total++;
    if (DinReady !== 1'b1)
      $display("FAIL bp_reassert: got %b want 1", DinReady);
    else pass_cnt++;
    if (Dout1Valid) got.push_back(Dout1);
    tick();
    DinValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (Dout1Valid) got.push_back(Dout1);
      tick();
    end
    total++;
    if (got.size() !== 3)
      $display("FAIL bp_count: got %0d want 3", got.size());
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        total++;
        if (got[i] !== w[i])
          $display("FAIL bp_order%0d: got %h want %h", i, got[i], w[i]);
        else pass_cnt++;
      end
    end
    Dout1Ready = 1'b0;
  endtask

  task automatic test_independent();
    logic [31:0] a0;
    logic [31:0] a1;
    a0 = $urandom;
    a1 = $urandom;
    Dout0Ready = 1'b0;
    Dout1Ready = 1'b1;
    Sel = 1'b0;
    DinValid = 1'b1;
    Din = a0;
    tick();
    Din = a1;
    tick();
    for (int i = 0; i < 6; i++) begin
      Sel = 1'b1;
      Din = $urandom;
      #1;
      total++;
      if (DinReady !== 1'b1)
        $display("FAIL ind_ready%0d: got %b want 1", i, DinReady);
      else pass_cnt++;
      total++;
      if ({Dout0Valid, Dout0} !== {1'b1, a0})
        $display("FAIL ind_hold%0d: got %b %h want 1 %h", i, Dout0Valid, Dout0, a0);
      else pass_cnt++;
      total++;
      if (Dout1Valid !== (q1.size() != 0))
        $display("FAIL ind_v1_%0d: got %b want %b", i, Dout1Valid, q1.size() != 0);
      else pass_cnt++;
      if (q1.size() != 0) begin
        total++;
        if (Dout1 !== q1[0])
          $display("FAIL ind_d1_%0d: got %h want %h", i, Dout1, q1[0]);
        else pass_cnt++;
      end
      tick();
    end
    DinValid = 1'b0;
    Dout0Ready = 1'b1;
    total++;
    if (Dout0 !== a0)
      $display("FAIL ind_drain0: got %h want %h", Dout0, a0);
    else pass_cnt++;
    tick();
    total++;
    if ({Dout0Valid, Dout0} !== {1'b1, a1})
      $display("FAIL ind_drain1: got %b %h want 1 %h", Dout0Valid, Dout0, a1);
    else pass_cnt++;
    tick();
    total++;
    if ({Dout0Valid, Dout1Valid} !== 2'b00)
      $display("FAIL ind_empty: got %b want 00", {Dout0Valid, Dout1Valid});
    else pass_cnt++;
    Dout0Ready = 1'b0;
    Dout1Ready = 1'b0;
  endtask

  task automatic test_count1();
    logic [31:0] x;
    logic [31:0] y;
    x = $urandom;
    y = $urandom;
    Dout0Ready = 1'b0;
    Sel = 1'b0;
    DinValid = 1'b1;
    Din = x;
    tick();
    Din = y;
    Dout0Ready = 1'b1;
    #1;
    total++;
    if (DinReady !== 1'b1)
      $display("FAIL c1_ready: got %b want 1", DinReady);
    else pass_cnt++;
    total++;
    if ({Dout0Valid, Dout0} !== {1'b1, x})
      $display("FAIL c1_old: got %b %h want 1 %h", Dout0Valid, Dout0, x);
    else pass_cnt++;
    tick();
    DinValid = 1'b0;
    total++;
    if ({Dout0Valid, Dout0} !== {1'b1, y})
      $display("FAIL c1_new: got %b %h want 1 %h", Dout0Valid, Dout0, y);
    else pass_cnt++;
    tick();
    total++;
    if (Dout0Valid !== 1'b0)
      $display("FAIL c1_empty: got %b want 0", Dout0Valid);
    else pass_cnt++;
    Dout0Ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    z = $urandom;
    Dout0Ready = 1'b0;
    Dout1Ready = 1'b0;
    DinValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Sel = i[0];
      Din = $urandom;
      tick();
    end
    total++;
    if ({Dout0Valid, Dout1Valid} !== 2'b11)
      $display("FAIL rm_full: got %b want 11", {Dout0Valid, Dout1Valid});
    else pass_cnt++;
    Rst = 1'b1;
    Sel = 1'b0;
    #1;
    total++;
    if (DinReady !== 1'b0)
      $display("FAIL rm_ready: got %b want 0", DinReady);
    else pass_cnt++;
    tick();
    Rst = 1'b0;
    DinValid = 1'b0;
    total++;
    if ({Dout0Valid, Dout1Valid} !== 2'b00)
      $display("FAIL rm_valid: got %b want 00", {Dout0Valid, Dout1Valid});
    else pass_cnt++;
    total++;
    if ({Dout0, Dout1} !== 64'h0)
      $display("FAIL rm_dout: got %h %h want 0 0", Dout0, Dout1);
    else pass_cnt++;
    Sel = 1'b1;
    Din = z;
    DinValid = 1'b1;
    Dout1Ready = 1'b1;
    tick();
    DinValid = 1'b0;
    total++;
    if ({Dout1Valid, Dout1} !== {1'b1, z})
      $display("FAIL rm_after: got %b %h want 1 %h", Dout1Valid, Dout1, z);
    else pass_cnt++;
    tick();
    Dout1Ready = 1'b0;
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    force dut.cnt0_q = 16'hFFFE;
    tick();
    release dut.cnt0_q;
    m_cnt0 = 16'hFFFE;
    Dout0Ready = 1'b1;
    Sel = 1'b0;
    DinValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Din = $urandom;
      tick();
    end
    DinValid = 1'b0;
    tick();
    tick();
    total++;
    if (Cnt0 !== 16'hFFFF)
      $display("FAIL stats_sat: got %h want ffff", Cnt0);
    else pass_cnt++;
    total++;
    if (Cnt0 !== m_cnt0)
      $display("FAIL stats_model: got %h want %h", Cnt0, m_cnt0);
    else pass_cnt++;
    Dout0Ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!(DinValid && !exp_ready())) begin
        DinValid = ($urandom % 4) != 0;
        Sel = $urandom % 2;
        Din = $urandom;
      end
      Dout0Ready = (i < 300) ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
      Dout1Ready = $urandom % 2;
      Rst = ($urandom % 100) == 0;
      #1;
      total++;
      if (DinReady !== exp_ready())
        $display("FAIL rnd_ready@%0d: got %b want %b", i, DinReady, exp_ready());
      else pass_cnt++;
      total++;
      if ({Dout0Valid, Dout1Valid} !== {q0.size() != 0, q1.size() != 0})
        $display("FAIL rnd_valid@%0d: got %b%b want %b%b", i, Dout0Valid,
                 Dout1Valid, q0.size() != 0, q1.size() != 0);
      else pass_cnt++;
      if (q0.size() != 0) begin
        total++;
        if (Dout0 !== q0[0])
          $display("FAIL rnd_d0@%0d: got %h want %h", i, Dout0, q0[0]);
        else pass_cnt++;
      end
      if (q1.size() != 0) begin
        total++;
        if (Dout1 !== q1[0])
          $display("FAIL rnd_d1@%0d: got %h want %h", i, Dout1, q1[0]);
        else pass_cnt++;
      end
`ifdef DEMUX_STATS_EN
      total++;
      if ({Cnt0, Cnt1} !== {m_cnt0, m_cnt1})
        $display("FAIL rnd_cnt@%0d: got %h %h want %h %h", i, Cnt0, Cnt1,
                 m_cnt0, m_cnt1);
      else pass_cnt++;
`endif
      tick();
    end
    Rst = 1'b0;
    DinValid = 1'b0;
  endtask

  initial begin
    Rst = 1'b1;
    Din = '0;
    Sel = 1'b0;
    DinValid = 1'b0;
    Dout0Ready = 1'b0;
    Dout1Ready = 1'b0;
`ifdef DEMUX_STATS_EN
    m_cnt0 = '0;
    m_cnt1 = '0;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_independent();
    test_count1();
    test_reset_mid();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
